// File: rtl/enc_ctrl_pkg.sv
// Shared state encoding and default sizes for the encoder window controller.
package enc_ctrl_pkg;

    localparam int ENC_TICK_W_DEF = 10;
    localparam int ENC_WIN_W_DEF  = 16;
    localparam int ENC_SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } enc_state_e;

endpackage

// File: rtl/encoder_edge_sync.sv
// Brings one asynchronous encoder pin into the clk domain and flags its rising edges.
module encoder_edge_sync
    import enc_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic [ENC_SYNC_DEPTH-1:0] sync_q, sync_d;
    logic                      prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[ENC_SYNC_DEPTH-2:0], pin};
        prev_d = sync_q[ENC_SYNC_DEPTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Level and edge are both taken from the last synchronizer stage so they stay aligned.
    assign level = sync_q[ENC_SYNC_DEPTH-1];
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/encoder_window_ctrl.sv
// Counts encoder edges over repeating windows of window_len clk cycles and publishes each total.
// Define ENC_QUAD_DIR_EN for signed x1 quadrature counting with direction from channel B.
module encoder_window_ctrl
    import enc_ctrl_pkg::*;
#(
    parameter int TICK_W = ENC_TICK_W_DEF,
    parameter int WIN_W  = ENC_WIN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_a,
    input  logic              enc_b,
    input  logic [WIN_W-1:0]  window_len,
    input  logic              start,
    input  logic              stop,
    input  logic              sample_ack,
    output logic [TICK_W-1:0] ticks,
    output logic              sample_valid,
    output logic              ovf,
    output logic              overrun,
    output logic              busy,
    output logic              dir
);

    localparam logic [TICK_W-1:0] CNT_ONE = TICK_W'(1);
    localparam logic [WIN_W-1:0]  WIN_ONE = WIN_W'(1);
`ifdef ENC_QUAD_DIR_EN
    localparam logic [TICK_W-1:0] CNT_HI = {1'b0, {(TICK_W-1){1'b1}}};
    localparam logic [TICK_W-1:0] CNT_LO = {1'b1, {(TICK_W-1){1'b0}}};
`else
    localparam logic [TICK_W-1:0] CNT_HI = '1;
`endif

    // Saturating steps return {hit_limit, next_count}.
    function automatic logic [TICK_W:0] sat_inc(input logic [TICK_W-1:0] cnt,
                                                input logic [TICK_W-1:0] lim);
        return (cnt == lim) ? {1'b1, cnt} : {1'b0, cnt + CNT_ONE};
    endfunction

`ifdef ENC_QUAD_DIR_EN
    function automatic logic [TICK_W:0] sat_dec(input logic [TICK_W-1:0] cnt,
                                                input logic [TICK_W-1:0] lim);
        return (cnt == lim) ? {1'b1, cnt} : {1'b0, cnt - CNT_ONE};
    endfunction
`endif

    logic a_rise;
    logic a_level_unused;

    encoder_edge_sync u_sync_a (
        .clk   (clk),
        .rst   (rst),
        .pin   (enc_a),
        .level (a_level_unused),
        .rise  (a_rise)
    );

`ifdef ENC_QUAD_DIR_EN
    logic b_level;
    logic b_rise_unused;

    encoder_edge_sync u_sync_b (
        .clk   (clk),
        .rst   (rst),
        .pin   (enc_b),
        .level (b_level),
        .rise  (b_rise_unused)
    );
`else
    logic enc_b_unused;
    assign enc_b_unused = enc_b;
`endif

    enc_state_e        state_q, state_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic              sat_q, sat_d;
    logic [TICK_W-1:0] ticks_q, ticks_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              dir_q, dir_d;

    logic [WIN_W-1:0]  win_reload;
    logic [TICK_W:0]   step;
    logic [TICK_W-1:0] cnt_nx;
    logic              sat_nx;
    logic              pub_dir;
    logic              publish;

    // A zero-length window behaves as a one-cycle window.
    assign win_reload = (window_len == '0) ? '0 : window_len - WIN_ONE;

    always_comb begin
        step = {1'b0, cnt_q};
        if (a_rise) begin
`ifdef ENC_QUAD_DIR_EN
            step = b_level ? sat_dec(cnt_q, CNT_LO) : sat_inc(cnt_q, CNT_HI);
`else
            step = sat_inc(cnt_q, CNT_HI);
`endif
        end
        cnt_nx = step[TICK_W-1:0];
        sat_nx = sat_q | step[TICK_W];
`ifdef ENC_QUAD_DIR_EN
        pub_dir = cnt_nx[TICK_W-1];
`else
        pub_dir = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        ticks_d   = ticks_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        dir_d     = dir_q;
        publish   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                sat_d = 1'b0;
                win_d = '0;
                if (start && !stop) begin
                    state_d = ST_RUN;
                    win_d   = win_reload;
                end
            end
            ST_RUN, ST_DRAIN: begin
                cnt_d = cnt_nx;
                sat_d = sat_nx;
                if (win_q == '0) begin
                    // Terminal cycle: this cycle's edge lands in the published total.
                    publish = 1'b1;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    win_d   = win_reload;
                    if (state_q == ST_DRAIN || stop) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    win_d = win_q - WIN_ONE;
                    if (state_q == ST_RUN && stop) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (publish) begin
            ticks_d = cnt_nx;
            ovf_d   = sat_nx;
            dir_d   = pub_dir;
            valid_d = 1'b1;
            if (valid_q && !sample_ack) begin
                overrun_d = 1'b1;
            end
        end else if (sample_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            ticks_q   <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            ticks_q   <= ticks_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            dir_q     <= dir_d;
        end
    end

    assign ticks        = ticks_q;
    assign sample_valid = valid_q;
    assign ovf          = ovf_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != ST_IDLE);
    assign dir          = dir_q;

endmodule

// File: tb/tb_encoder_window_ctrl.sv
// Self-checking bench for encoder_window_ctrl: vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_encoder_window_ctrl;

    localparam int TICK_W = 10;
    localparam int WIN_W  = 16;
`ifdef ENC_QUAD_DIR_EN
    localparam logic [TICK_W-1:0] SAT_FWD = 10'h1FF;
    localparam logic [TICK_W-1:0] REV_25  = 10'h3E7;
    localparam logic              REV_DIR = 1'b1;
`else
    localparam logic [TICK_W-1:0] SAT_FWD = 10'h3FF;
    localparam logic [TICK_W-1:0] REV_25  = 10'd25;
    localparam logic              REV_DIR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              enc_a = 1'b0;
    logic              enc_b;
    logic [WIN_W-1:0]  window_len;
    logic              start;
    logic              stop;
    logic              man_ack;
    logic              auto_ack_r = 1'b0;
    logic              sample_ack;
    logic [TICK_W-1:0] ticks;
    logic              sample_valid;
    logic              ovf;
    logic              overrun;
    logic              busy;
    logic              dir;

    assign sample_ack = man_ack | auto_ack_r;

    encoder_window_ctrl #(.TICK_W(TICK_W), .WIN_W(WIN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enc_a        (enc_a),
        .enc_b        (enc_b),
        .window_len   (window_len),
        .start        (start),
        .stop         (stop),
        .sample_ack   (sample_ack),
        .ticks        (ticks),
        .sample_valid (sample_valid),
        .ovf          (ovf),
        .overrun      (overrun),
        .busy         (busy),
        .dir          (dir)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Encoder A: square wave of enc_period clk cycles, changed away from the sampling edge.
    int enc_period = 0;
    int enc_ph = 0;
    always @(negedge clk) begin
        if (enc_period < 2) begin
            enc_a  = 1'b0;
            enc_ph = 0;
        end else begin
            enc_a  = (enc_ph < enc_period / 2);
            enc_ph = (enc_ph + 1) % enc_period;
        end
    end

    typedef struct {
        logic [TICK_W-1:0] ticks;
        logic              ovf;
        logic              dir;
        int                gap;
    } exp_t;

    typedef struct {
        int                win;
        int                period;
        logic              b;
        int                nwin;
        logic [TICK_W-1:0] ticks;
        logic              ovf;
        logic              dir;
    } vec_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   pub_cnt = 0;
    int   last_pub = 0;
    logic prev_valid = 1'b0;
    logic auto_on = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic push_exp(input logic [TICK_W-1:0] t, input logic o, input logic d, input int gap);
        exp_t e;
        e.ticks = t;
        e.ovf   = o;
        e.dir   = d;
        e.gap   = gap;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every new sample_valid rise consumes one queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sample_valid && !prev_valid && !rst) begin
            pub_cnt++;
            check("pub_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pub_ticks", int'(ticks), int'(e.ticks));
                check("pub_ovf", int'(ovf), int'(e.ovf));
                check("pub_dir", int'(dir), int'(e.dir));
                if (e.gap != 0) check("pub_gap", cyc - last_pub, e.gap);
            end
            last_pub = cyc;
        end
        auto_ack_r = auto_on && sample_valid;
        prev_valid = sample_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop;
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_pubs(input int target, input int budget, input string name);
        int n = 0;
        while (pub_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        check(name, pub_cnt, target);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!sample_valid && n < budget) begin
            tick(1);
            n++;
        end
        check(name, int'(sample_valid), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ticks"}, int'(ticks), 0);
        check({tag, "_valid"}, int'(sample_valid), 0);
        check({tag, "_ovf"}, int'(ovf), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_dir"}, int'(dir), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   base;

        vecs[0] = '{100,  4, 1'b0, 3, 10'd25,  1'b0, 1'b0};
        vecs[1] = '{5000, 2, 1'b0, 1, SAT_FWD, 1'b1, 1'b0};
        vecs[2] = '{100,  4, 1'b1, 2, REV_25,  1'b0, REV_DIR};
        vecs[3] = '{40,   8, 1'b0, 2, 10'd5,   1'b0, 1'b0};

        rst        = 1'b1;
        enc_b      = 1'b0;
        window_len = '0;
        start      = 1'b0;
        stop       = 1'b0;
        man_ack    = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // Stop in IDLE, and start with stop in the same cycle, must both leave the FSM idle.
        pulse_stop;
        check("idle_stop_busy", int'(busy), 0);
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_busy", int'(busy), 0);
        tick(2);
        check("start_stop_busy_later", int'(busy), 0);

        auto_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            window_len = WIN_W'(vecs[i].win);
            enc_period = vecs[i].period;
            enc_b      = vecs[i].b;
            tick(10);
            base = pub_cnt;
            for (int w = 0; w < vecs[i].nwin; w++)
                push_exp(vecs[i].ticks, vecs[i].ovf, vecs[i].dir, (w == 0) ? 0 : vecs[i].win);
            pulse_start;
            check("vec_busy", int'(busy), 1);
            if (vecs[i].nwin > 1)
                wait_pubs(base + vecs[i].nwin - 1, vecs[i].win * vecs[i].nwin + 50, "vec_pubs");
            tick(3);
            pulse_stop;
            wait_idle(vecs[i].win * 2 + 50, "vec_drain_idle");
            tick(2);
            check("vec_pub_count", pub_cnt, base + vecs[i].nwin);
            tick(60);
            check("vec_no_pub_after_stop", pub_cnt, base + vecs[i].nwin);
            check("vec_queue_drained", exp_q.size(), 0);
        end
        auto_on    = 1'b0;
        enc_b      = 1'b0;
        enc_period = 0;
        tick(5);

        // window_len of zero acts as a one-cycle window.
        window_len = '0;
        push_exp('0, 1'b0, 1'b0, 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("len0_busy", int'(busy), 1);
        check("len0_not_yet_valid", int'(sample_valid), 0);
        tick(1);
        check("len0_valid", int'(sample_valid), 1);
        check("len0_ticks", int'(ticks), 0);
        pulse_stop;
        wait_idle(20, "len0_idle");
        do_reset;

        // Two publishes with no ack in between raise the sticky overrun flag.
        window_len = WIN_W'(20);
        enc_period = 4;
        tick(10);
        push_exp(10'd5, 1'b0, 1'b0, 0);
        pulse_start;
        wait_valid(60, "ovr_first_valid");
        check("ovr_clear_after_first", int'(overrun), 0);
        tick(21);
        check("ovr_set", int'(overrun), 1);
        check("ovr_valid", int'(sample_valid), 1);
        check("ovr_ticks", int'(ticks), 5);
        pulse_stop;
        wait_idle(80, "ovr_idle");
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        check("ovr_ack_clears_valid", int'(sample_valid), 0);
        check("ovr_sticky", int'(overrun), 1);
        do_reset;
        check("ovr_reset_clears", int'(overrun), 0);

        // Ack landing on the same edge as a publish: no overrun, sample stays valid.
        tick(10);
        push_exp(10'd5, 1'b0, 1'b0, 0);
        pulse_start;
        wait_valid(60, "ackpub_first_valid");
        tick(19);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        check("ackpub_valid", int'(sample_valid), 1);
        check("ackpub_overrun", int'(overrun), 0);
        check("ackpub_ticks", int'(ticks), 5);
        tick(1);
        check("ackpub_valid_held", int'(sample_valid), 1);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        check("ackpub_ack_clears", int'(sample_valid), 0);
        push_exp(10'd5, 1'b0, 1'b0, 0);
        pulse_stop;
        wait_idle(80, "ackpub_idle");
        tick(2);
        check("ackpub_overrun_final", int'(overrun), 0);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;

        // Asynchronous reset in the middle of a window discards it at once.
        auto_on    = 1'b1;
        window_len = WIN_W'(100);
        tick(10);
        base = pub_cnt;
        push_exp(10'd25, 1'b0, 1'b0, 0);
        pulse_start;
        wait_pubs(base + 1, 200, "rst_first_pub");
        tick(30);
        check("rst_pre_ticks", int'(ticks), 25);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        tick(2);
        rst = 1'b0;
        tick(250);
        check("rst_no_pub", pub_cnt, base + 1);
        check("rst_stays_idle", int'(busy), 0);
        check("rst_valid_low", int'(sample_valid), 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_window_ctrl.md
ENCODER_WINDOW_CTRL -- requirements
Module: encoder_window_ctrl

Interface
REQ-001 SHALL have parameter TICK_W, default 10, width of the tick count.
REQ-002 SHALL have parameter WIN_W, default 16, width of the window length.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enc_a  input  1  encoder channel A (q0), asynchronous to clk.
REQ-006 SHALL have port enc_b  input  1  encoder channel B, asynchronous; used only under ENC_QUAD_DIR_EN.
REQ-007 SHALL have port window_len  input  WIN_W  sample window in clk cycles, sampled at window (re)load.
REQ-008 SHALL have port start  input  1  single-cycle request to begin sampling.
REQ-009 SHALL have port stop  input  1  single-cycle request to end sampling after the current window.
REQ-010 SHALL have port sample_ack  input  1  consumer acknowledge of ticks.
REQ-011 SHALL have port ticks  output  TICK_W  last published window count (TICKS).
REQ-012 SHALL have port sample_valid  output  1  ticks holds an unacknowledged sample.
REQ-013 SHALL have port ovf  output  1  published window saturated.
REQ-014 SHALL have port overrun  output  1  sticky: a sample was overwritten before ack.
REQ-015 SHALL have port busy  output  1  FSM not in IDLE.
REQ-016 SHALL have port dir  output  1  direction of last published window (1 = reverse).

Function
REQ-017 SHALL pass enc_a/enc_b through 2-FF synchronizers plus one edge-detect register; a pin rising edge is counted 3 cycles later.
REQ-018 SHALL implement FSM IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on stop; DRAIN->IDLE at window end; stop in IDLE ignored; start and stop in same IDLE cycle -> stays IDLE.
REQ-019 SHALL on entering RUN, clear the internal count and load window counter with window_len-1; window_len=0 SHALL be treated as 1.
REQ-020 SHALL in RUN/DRAIN decrement the window counter each cycle and add each detected edge to the count, saturating at 2^TICK_W-1 with a window-local saturation flag.
REQ-021 SHALL at the terminal cycle (counter=0) publish: ticks <= count including any edge in that cycle, ovf <= saturation flag, sample_valid <= 1.
REQ-022 SHALL in RUN at the terminal cycle reload the counter from window_len and restart the count at 0 in the next cycle with no lost edges.
REQ-023 SHALL clear sample_valid on sample_ack while valid; sample_ack while not valid has no effect.
REQ-024 SHALL on publish with sample_valid=1 and no sample_ack in the same cycle set overrun; publish with simultaneous ack leaves overrun unchanged and sample_valid=1.
REQ-025 SHALL treat start while busy as ignored; stop in DRAIN ignored.

Reset
REQ-026 SHALL on rst force FSM=IDLE, counters=0, ticks=0, sample_valid=0, ovf=0, overrun=0, dir=0, synchronizers=0, regardless of clk.
REQ-027 SHALL on rst mid-window discard the partial window without publishing; overrun clears only on reset.

Configuration
REQ-028 SHALL with ENC_QUAD_DIR_EN defined decode x1 quadrature: rising A with B=0 counts +1, with B=1 counts -1; count is two's-complement TICK_W, saturating at +(2^(TICK_W-1)-1) and -(2^(TICK_W-1)); dir = sign of published count.
REQ-029 SHALL without ENC_QUAD_DIR_EN count rising edges of A unsigned, ignore enc_b, and tie dir to 0.

Structure
REQ-030 SHALL place FSM state enum, default TICK_W/WIN_W and synchronizer depth in shared package enc_ctrl_pkg.
REQ-031 SHALL instantiate one sub-module encoder_edge_sync (synchronizer + rising-edge detect, one per channel).

Verification
REQ-032 SHALL cover: window_len=100, enc_a period 4 clk, start -> ticks=25, sample_valid=1 every 100 cycles, ovf=0.
REQ-033 SHALL cover: window_len=5000, enc_a period 2 clk -> ticks=1023, ovf=1.
REQ-034 SHALL cover: no sample_ack across two publishes -> overrun=1; ack in same cycle as publish -> overrun=0, sample_valid=1.
REQ-035 SHALL cover: stop mid-window -> current window published, then busy=0 and no further publishes; start+stop same IDLE cycle -> busy stays 0.
REQ-036 SHALL cover: rst asserted mid-window -> all outputs 0 immediately, no publish; under ENC_QUAD_DIR_EN with B leading (B=1 at A rise) -> ticks=-25 (0x3E7), dir=1.
